// File: rtl/cache_data_array_nway_if.sv
// Bundle of the cache data array's request/response signals.
// The master side (controller / memory fill path) drives requests.
// The slave side (the data array) returns read data and sequencer status.
interface cache_data_array_nway_if #(
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int WORD_W = 16
);
  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WORDS);
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic              rd_req;
  logic [AW-1:0]     rd_way;
  logic [SW-1:0]     rd_set;
  logic [WW-1:0]     rd_word;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;

  logic              wr_en;
  logic [AW-1:0]     wr_way;
  logic [SW-1:0]     wr_set;
  logic [WW-1:0]     wr_word;
  logic [WORD_W-1:0] wr_data;
  logic              wr_stall;

  logic              fill_start;
  logic [AW-1:0]     fill_way;
  logic [SW-1:0]     fill_set;
  logic              fill_beat;
  logic [WORD_W-1:0] fill_data;
  logic              fill_busy;
  logic              fill_done;

  modport master (
    output rd_req, rd_way, rd_set, rd_word,
    output wr_en, wr_way, wr_set, wr_word, wr_data,
    output fill_start, fill_way, fill_set, fill_beat, fill_data,
    input  rd_data, rd_valid, wr_stall, fill_busy, fill_done
  );

  modport slave (
    input  rd_req, rd_way, rd_set, rd_word,
    input  wr_en, wr_way, wr_set, wr_word, wr_data,
    input  fill_start, fill_way, fill_set, fill_beat, fill_data,
    output rd_data, rd_valid, wr_stall, fill_busy, fill_done
  );
endinterface

// File: rtl/cache_data_array_nway.sv
// N-way set-associative cache data store.
// Registered read port with read-before-write behaviour, a single-word write
// port, and a line-fill sequencer that writes one block beat by beat.
// Storage is flop-based so that reset can clear every word.
module cache_data_array_nway #(
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int WORD_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  cache_data_array_nway_if.slave bus
);
  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WORDS);
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [AW:0]   WAYS_L   = (AW+1)'(WAYS);
  localparam logic [WW-1:0] LAST_WRD = WW'(WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [AW-1:0]     f_way;
  logic [SW-1:0]     f_set;
  logic [WW-1:0]     cnt;
  logic              fill_busy;
  logic [WORD_W-1:0] rd_data_p1;
  logic              vld_p1;
  logic [WORD_W-1:0] mem [WAYS][SETS][WORDS];

  // A way index is only backed by storage when it is below WAYS.
  function automatic logic way_ok(input logic [AW-1:0] w);
    return ({1'b0, w} < WAYS_L);
  endfunction

  assign fill_busy     = (state == FILL);
  assign bus.fill_busy = fill_busy;
  assign bus.wr_stall  = fill_busy;
  assign bus.fill_done = (state == DONE);
  assign bus.rd_data   = rd_data_p1;
  assign bus.rd_valid  = vld_p1;

  // Read stage: sample the old contents so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= bus.rd_req;
      if (bus.rd_req)
        rd_data_p1 <= way_ok(bus.rd_way) ? mem[bus.rd_way][bus.rd_set][bus.rd_word] : '0;
    end
  end

  // Fill sequencer: latch the target line, count beats, pulse done once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      f_way <= '0;
      f_set <= '0;
    end else begin
      case (state)
        IDLE: if (bus.fill_start) begin
          f_way <= bus.fill_way;
          f_set <= bus.fill_set;
          cnt   <= '0;
          state <= FILL;
        end
        FILL: if (bus.fill_beat) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_WRD) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage update: host writes only outside FILL, fill beats only inside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          for (int d = 0; d < WORDS; d++)
            mem[w][s][d] <= '0;
    end else begin
      if (bus.wr_en && !fill_busy && way_ok(bus.wr_way))
        mem[bus.wr_way][bus.wr_set][bus.wr_word] <= bus.wr_data;
      if (fill_busy && bus.fill_beat && way_ok(f_way))
        mem[f_way][f_set][cnt] <= bus.fill_data;
    end
  end
endmodule

// File: tb/tb_cache_data_array_nway.sv
// Bench for cache_data_array_nway: directed scenarios with literal
// expectations plus a randomized phase, all checked against a behavioural
// model of the array and the fill sequence.
module tb_cache_data_array_nway;
  localparam int WAYS = 2, SETS = 64, WORDS = 8, WORD_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  cache_data_array_nway_if #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .WORD_W(WORD_W)) bus ();
  cache_data_array_nway_if #(.WAYS(4), .SETS(16), .WORDS(4), .WORD_W(32)) bus2 ();

  cache_data_array_nway #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  cache_data_array_nway #(.WAYS(4), .SETS(16), .WORDS(4), .WORD_W(32)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WORD_W-1:0] m [WAYS][SETS][WORDS];
  bit                m_active, m_done;
  int                m_n, m_way, m_set;
  logic [WORD_W-1:0] e_rd_data;
  bit                e_rd_valid;

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++)
        for (int d = 0; d < WORDS; d++) m[w][s][d] = '0;
    m_active = 0; m_done = 0; m_n = 0; m_way = 0; m_set = 0;
    e_rd_data = '0; e_rd_valid = 0;
  endtask

  always @(posedge clk) begin : model_p
    bit busy;
    if (rst) begin
      busy = m_active;
      e_rd_valid = bus.rd_req;
      if (bus.rd_req)
        e_rd_data = (int'(bus.rd_way) < WAYS) ? m[bus.rd_way][bus.rd_set][bus.rd_word] : '0;
      if (bus.wr_en && !busy) m[bus.wr_way][bus.wr_set][bus.wr_word] = bus.wr_data;
      if (m_done) m_done = 0;
      else if (busy) begin
        if (bus.fill_beat) begin
          m[m_way][m_set][m_n] = bus.fill_data;
          m_n++;
          if (m_n == WORDS) begin m_active = 0; m_done = 1; end
        end
      end else if (bus.fill_start) begin
        m_active = 1; m_n = 0; m_way = int'(bus.fill_way); m_set = int'(bus.fill_set);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("cyc_rd_valid", 64'(bus.rd_valid), 64'(e_rd_valid));
      chk("cyc_rd_data", 64'(bus.rd_data), 64'(e_rd_data));
      chk("cyc_fill_busy", 64'(bus.fill_busy), 64'(m_active));
      chk("cyc_wr_stall", 64'(bus.wr_stall), 64'(m_active));
      chk("cyc_fill_done", 64'(bus.fill_done), 64'(m_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd(input int w, input int s, input int d);
    bus.rd_req = 1; bus.rd_way = 1'(w); bus.rd_set = 6'(s); bus.rd_word = 3'(d);
    step();
    bus.rd_req = 0;
  endtask

  task automatic wr(input int w, input int s, input int d, input logic [15:0] v);
    bus.wr_en = 1; bus.wr_way = 1'(w); bus.wr_set = 6'(s); bus.wr_word = 3'(d); bus.wr_data = v;
    step();
    bus.wr_en = 0;
  endtask

  task automatic idle_inputs();
    bus.rd_req = 0; bus.rd_way = '0; bus.rd_set = '0; bus.rd_word = '0;
    bus.wr_en = 0; bus.wr_way = '0; bus.wr_set = '0; bus.wr_word = '0; bus.wr_data = '0;
    bus.fill_start = 0; bus.fill_way = '0; bus.fill_set = '0; bus.fill_beat = 0; bus.fill_data = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus2.rd_req = 0; bus2.rd_way = '0; bus2.rd_set = '0; bus2.rd_word = '0;
    bus2.wr_en = 0; bus2.wr_way = '0; bus2.wr_set = '0; bus2.wr_word = '0; bus2.wr_data = '0;
    bus2.fill_start = 0; bus2.fill_way = '0; bus2.fill_set = '0; bus2.fill_beat = 0; bus2.fill_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cmp_en = 1'b1;

    // 1: reset state and first read
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_fill_busy", 64'(bus.fill_busy), 64'd0);
    chk("rst_fill_done", 64'(bus.fill_done), 64'd0);
    rd(1, 63, 7);
    chk("t1_rd_valid", 64'(bus.rd_valid), 64'd1);
    chk("t1_rd_data", 64'(bus.rd_data), 64'd0);
    step();
    chk("t1_valid_drop", 64'(bus.rd_valid), 64'd0);

    // 2: write then read, way isolation
    wr(0, 5, 3, 16'hBEEF);
    rd(0, 5, 3);
    chk("t2_beef", 64'(bus.rd_data), 64'hBEEF);
    rd(1, 5, 3);
    chk("t2_isolation", 64'(bus.rd_data), 64'h0);

    // 3/4: fill way1/set10 with gaps, stalled write and ignored restart
    bus.fill_start = 1; bus.fill_way = 1'b1; bus.fill_set = 6'd10;
    step();
    bus.fill_start = 0;
    chk("t3_busy_start", 64'(bus.fill_busy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      bus.fill_beat = 1; bus.fill_data = 16'(16'h1000 + i);
      if (i == 3) begin
        bus.wr_en = 1; bus.wr_way = 1'b0; bus.wr_set = 6'd0; bus.wr_word = 3'd0; bus.wr_data = 16'hDEAD;
        bus.fill_start = 1; bus.fill_way = 1'b0; bus.fill_set = 6'd0;
        chk("t4_wr_stall", 64'(bus.wr_stall), 64'd1);
      end
      step();
      bus.wr_en = 0; bus.fill_start = 0; bus.fill_beat = 0;
      if (i < 7) chk("t3_busy_mid", 64'(bus.fill_busy), 64'd1);
      if (i == 2 || i == 5) begin
        step();
        chk("t3_busy_gap", 64'(bus.fill_busy), 64'd1);
        chk("t3_no_done_gap", 64'(bus.fill_done), 64'd0);
      end
    end
    chk("t3_done_pulse", 64'(bus.fill_done), 64'd1);
    chk("t3_busy_end", 64'(bus.fill_busy), 64'd0);
    step();
    chk("t3_done_once", 64'(bus.fill_done), 64'd0);
    for (int i = 0; i < 8; i++) begin
      rd(1, 10, i);
      chk("t3_fill_word", 64'(bus.rd_data), 64'(16'h1000 + i));
    end
    rd(0, 0, 0);
    chk("t4_stalled_wr", 64'(bus.rd_data), 64'h0);

    // 5: same-cycle read and write returns old data
    bus.rd_req = 1; bus.rd_way = 1'b0; bus.rd_set = 6'd1; bus.rd_word = 3'd1;
    wr(0, 1, 1, 16'h1234);
    bus.rd_req = 0;
    chk("t5_old", 64'(bus.rd_data), 64'h0);
    rd(0, 1, 1);
    chk("t5_new", 64'(bus.rd_data), 64'h1234);

    // second configuration: 4 ways, 16 sets, 4 words, 32-bit
    bus2.wr_en = 1; bus2.wr_way = 2'd0; bus2.wr_set = 4'd5; bus2.wr_word = 2'd3; bus2.wr_data = 32'h0000BEEF;
    step();
    bus2.wr_en = 1; bus2.wr_way = 2'd3; bus2.wr_set = 4'd15; bus2.wr_word = 2'd3; bus2.wr_data = 32'hCAFEF00D;
    bus2.rd_req = 1; bus2.rd_way = 2'd0; bus2.rd_set = 4'd5; bus2.rd_word = 2'd3;
    step();
    bus2.wr_en = 0;
    chk("c2_beef", 64'(bus2.rd_data), 64'h0000BEEF);
    bus2.rd_way = 2'd1;
    step();
    chk("c2_isolation", 64'(bus2.rd_data), 64'h0);
    bus2.rd_way = 2'd3; bus2.rd_set = 4'd15;
    step();
    bus2.rd_req = 0;
    chk("c2_way3", 64'(bus2.rd_data), 64'hCAFEF00D);

    // randomized traffic on a few sets so reads, writes and fills collide
    for (int n = 0; n < 3000; n++) begin
      bus.rd_req  = 1'($urandom_range(0, 1));
      bus.rd_way  = 1'($urandom_range(0, 1));
      bus.rd_set  = 6'($urandom_range(0, 3));
      bus.rd_word = 3'($urandom_range(0, 7));
      bus.wr_en   = ($urandom_range(0, 9) < 3);
      bus.wr_way  = 1'($urandom_range(0, 1));
      bus.wr_set  = 6'($urandom_range(0, 3));
      bus.wr_word = 3'($urandom_range(0, 7));
      bus.wr_data = 16'($urandom);
      bus.fill_start = ($urandom_range(0, 19) == 0);
      bus.fill_way   = 1'($urandom_range(0, 1));
      bus.fill_set   = 6'($urandom_range(0, 3));
      bus.fill_beat  = ($urandom_range(0, 9) < 6);
      bus.fill_data  = 16'($urandom);
      step();
    end
    idle_inputs();
    repeat (3) step();

    // 6: reset in the middle of a fill
    bus.fill_start = 1; bus.fill_way = 1'b0; bus.fill_set = 6'd20;
    step();
    bus.fill_start = 0;
    for (int i = 0; i < 4; i++) begin
      bus.fill_beat = 1; bus.fill_data = 16'(16'h2000 + i);
      step();
    end
    bus.fill_beat = 0;
    chk("t6_busy_before", 64'(bus.fill_busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_busy_async", 64'(bus.fill_busy), 64'd0);
    chk("t6_no_done", 64'(bus.fill_done), 64'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    step();
    chk("t6_done_after", 64'(bus.fill_done), 64'd0);
    rd(0, 20, 0);
    chk("t6_fill_cleared", 64'(bus.rd_data), 64'h0);
    rd(1, 10, 0);
    chk("t6_line_cleared", 64'(bus.rd_data), 64'h0);
    rd(0, 1, 1);
    chk("t6_word_cleared", 64'(bus.rd_data), 64'h0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
